// File: rtl/cpu6502_hypervisor_port.sv
`default_nettype none
// ============================================================================
//  Module   : cpu6502_hypervisor_port
//  Purpose  : Hypervisor-side controller for the Cpu6502 register access port.
//             On a host command it halts the CPU by gating its clock enable,
//             then either snapshots the CPU registers into a local buffer
//             (save) or writes them back from that buffer (restore).
//  Ports    : clock/resetN          - system clock, async active-low reset
//             clockEnableIn/Out     - CPU clock enable in, gated enable out
//             hypervisorWrite, writeAddr, writeData - CPU register write port
//             readAddrA/B, readDataA/B              - CPU register read ports
//             cmdValid, cmdRestore, cmdReady        - host command handshake
//             busy, done                            - status / completion pulse
//             bufAddr, bufWriteEnable, bufWriteData, bufReadData - host buffer
//  Revision : 1.0 - initial release
// ============================================================================
module cpu6502_hypervisor_port #(
   parameter int HALT_CYCLES = 1,
   parameter int REG_COUNT   = 8
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       clockEnableIn,
   output logic       clockEnableOut,
   output logic       hypervisorWrite,
   output logic [2:0] writeAddr,
   output logic [7:0] writeData,
   output logic [2:0] readAddrA,
   input  logic [7:0] readDataA,
   output logic [2:0] readAddrB,
   input  logic [7:0] readDataB,
   input  logic       cmdValid,
   input  logic       cmdRestore,
   output logic       cmdReady,
   output logic       busy,
   output logic       done,
   input  logic [2:0] bufAddr,
   input  logic       bufWriteEnable,
   input  logic [7:0] bufWriteData,
   output logic [7:0] bufReadData
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_SAVE    = 3'd2,
      ST_RESTORE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [3:0] c_HALT_LOAD = 4'(HALT_CYCLES - 1);
   localparam logic [2:0] c_LAST_REG  = 3'(REG_COUNT - 1);
   // readAddrA value of the last even/odd pair
   localparam logic [2:0] c_LAST_PAIR = 3'(REG_COUNT - 2);

   state_t     r_state;
   state_t     w_nextState;
   logic       r_halt;
   logic       r_restore;
   logic [3:0] r_haltCount;
   logic [2:0] r_index;
   logic [2:0] r_readAddrA;
   logic [2:0] r_readAddrB;
   logic [7:0] r_bufReadData;
   logic [7:0] r_buffer [8];

   // State register
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_nextState     = r_state;
      cmdReady        = 1'b0;
      busy            = 1'b1;
      done            = 1'b0;
      hypervisorWrite = 1'b0;
      writeAddr       = 3'd0;
      writeData       = 8'h00;
      case (r_state)
         ST_IDLE: begin
            cmdReady = 1'b1;
            busy     = 1'b0;
            if (cmdValid) begin
               w_nextState = ST_HALT;
            end
         end
         ST_HALT: begin
            if (r_haltCount == 4'd0) begin
               w_nextState = r_restore ? ST_RESTORE : ST_SAVE;
            end
         end
         ST_SAVE: begin
            if (r_readAddrA == c_LAST_PAIR) begin
               w_nextState = ST_DONE;
            end
         end
         ST_RESTORE: begin
            hypervisorWrite = 1'b1;
            writeAddr       = r_index;
            writeData       = r_buffer[r_index];
            if (r_index == c_LAST_REG) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Datapath: halt flag, counters, read addresses and the register buffer
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_halt        <= 1'b0;
         r_restore     <= 1'b0;
         r_haltCount   <= 4'd0;
         r_index       <= 3'd0;
         r_readAddrA   <= 3'd0;
         r_readAddrB   <= 3'd0;
         r_bufReadData <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            r_buffer[i] <= 8'h00;
         end
      end else begin
         r_bufReadData <= r_buffer[bufAddr];
         case (r_state)
            ST_IDLE: begin
               // Host write lands on the accept edge too; a save then overwrites it
               if (bufWriteEnable) begin
                  r_buffer[bufAddr] <= bufWriteData;
               end
               if (cmdValid) begin
                  r_halt      <= 1'b1;
                  r_restore   <= cmdRestore;
                  r_haltCount <= c_HALT_LOAD;
               end
            end
            ST_HALT: begin
               if (r_haltCount != 4'd0) begin
                  r_haltCount <= r_haltCount - 4'd1;
               end else begin
                  // Addresses are set on the entry edge so the first SAVE
                  // cycle already sees stable read data
                  r_index     <= 3'd0;
                  r_readAddrA <= 3'd0;
                  r_readAddrB <= 3'd1;
               end
            end
            ST_SAVE: begin
               r_buffer[r_readAddrA] <= readDataA;
               r_buffer[r_readAddrB] <= readDataB;
               if (r_readAddrA != c_LAST_PAIR) begin
                  r_readAddrA <= r_readAddrA + 3'd2;
                  r_readAddrB <= r_readAddrB + 3'd2;
               end
            end
            ST_RESTORE: begin
               if (r_index != c_LAST_REG) begin
                  r_index <= r_index + 3'd1;
               end
            end
            ST_DONE: begin
               r_halt <= 1'b0;
            end
            default: begin
               r_halt <= 1'b0;
            end
         endcase
      end
   end

   assign clockEnableOut = clockEnableIn & ~r_halt;
   assign readAddrA      = r_readAddrA;
   assign readAddrB      = r_readAddrB;
   assign bufReadData    = r_bufReadData;

endmodule
`default_nettype wire

// File: tb/tb_cpu6502_hypervisor_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu6502_hypervisor_port
//  Purpose  : Self-checking bench for cpu6502_hypervisor_port. A default
//             instance (HALT_CYCLES=1) and a HALT_CYCLES=4 instance share a
//             behavioural CPU register file; a select bit routes host
//             commands and observation to one of them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu6502_hypervisor_port;

   localparam int R = 8;

   logic       clock = 1'b0;
   logic       resetN = 1'b0;
   logic       ceIn = 1'b0;
   logic       cmdValid = 1'b0;
   logic       cmdRestore = 1'b0;
   logic [2:0] bufAddr = 3'd0;
   logic       bufWe = 1'b0;
   logic [7:0] bufWd = 8'h00;
   logic       sel = 1'b0;

   logic [7:0] cpuRegs [8];
   logic [7:0] bufModel [8];

   logic       ce1, hw1, rdy1, busy1, done1, ce2, hw2, rdy2, busy2, done2;
   logic [2:0] wa1, ra1, rb1, wa2, ra2, rb2;
   logic [7:0] wd1, brd1, wd2, brd2, rdA1, rdB1, rdA2, rdB2;

   assign rdA1 = cpuRegs[ra1];
   assign rdB1 = cpuRegs[rb1];
   assign rdA2 = cpuRegs[ra2];
   assign rdB2 = cpuRegs[rb2];

   always #5 clock = ~clock;

   cpu6502_hypervisor_port #(.HALT_CYCLES(1), .REG_COUNT(R)) dut (
      .clock(clock), .resetN(resetN), .clockEnableIn(ceIn), .clockEnableOut(ce1),
      .hypervisorWrite(hw1), .writeAddr(wa1), .writeData(wd1),
      .readAddrA(ra1), .readDataA(rdA1), .readAddrB(rb1), .readDataB(rdB1),
      .cmdValid(cmdValid & ~sel), .cmdRestore(cmdRestore), .cmdReady(rdy1),
      .busy(busy1), .done(done1), .bufAddr(bufAddr), .bufWriteEnable(bufWe & ~sel),
      .bufWriteData(bufWd), .bufReadData(brd1));

   cpu6502_hypervisor_port #(.HALT_CYCLES(4), .REG_COUNT(R)) dutH4 (
      .clock(clock), .resetN(resetN), .clockEnableIn(ceIn), .clockEnableOut(ce2),
      .hypervisorWrite(hw2), .writeAddr(wa2), .writeData(wd2),
      .readAddrA(ra2), .readDataA(rdA2), .readAddrB(rb2), .readDataB(rdB2),
      .cmdValid(cmdValid & sel), .cmdRestore(cmdRestore), .cmdReady(rdy2),
      .busy(busy2), .done(done2), .bufAddr(bufAddr), .bufWriteEnable(bufWe & sel),
      .bufWriteData(bufWd), .bufReadData(brd2));

   wire       oCe   = sel ? ce2   : ce1;
   wire       oHw   = sel ? hw2   : hw1;
   wire       oRdy  = sel ? rdy2  : rdy1;
   wire       oBusy = sel ? busy2 : busy1;
   wire       oDone = sel ? done2 : done1;
   wire [2:0] oWa   = sel ? wa2   : wa1;
   wire [7:0] oWd   = sel ? wd2   : wd1;
   wire [7:0] oBrd  = sel ? brd2  : brd1;

   int checks = 0;
   int errors = 0;
   logic [10:0] wrQ [$];
   int          wrCycQ [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Host buffer write; caller is at a negedge, returns at a negedge
   task automatic bufWrite(input logic [2:0] a, input logic [7:0] d);
      bufAddr = a; bufWd = d; bufWe = 1'b1;
      @(negedge clock);
      bufWe = 1'b0;
   endtask

   // Compare all 8 buffer entries against the model (1-cycle read latency)
   task automatic checkBuf(input string tag);
      for (int i = 0; i < 8; i++) begin
         bufAddr = 3'(i);
         @(negedge clock);
         chk($sformatf("%s_buf%0d", tag, i), {24'd0, oBrd}, {24'd0, bufModel[i]});
      end
   endtask

   // Issue one command at the current negedge (cycle 0) and observe each
   // following cycle. At cycle intrudeAt a second command and a host buffer
   // write are attempted while busy. cwEn adds a host write on the accept cycle.
   task automatic runCmd(input logic restore, input int h, input int intrudeAt,
                         input bit ceRand, input bit cwEn, input logic [2:0] cwAddr,
                         input logic [7:0] cwData, input string tag);
      int  doneAt, nDone, gateBad, readyBad, expDone;
      bit  halted;
      expDone = restore ? h + R + 1 : h + R / 2 + 1;
      doneAt = -1; nDone = 0; gateBad = 0; readyBad = 0;
      wrQ.delete(); wrCycQ.delete();
      cmdRestore = restore; cmdValid = 1'b1;
      if (cwEn) begin
         bufAddr = cwAddr; bufWd = cwData; bufWe = 1'b1;
         bufModel[cwAddr] = cwData;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (oDone) begin
            nDone++;
            if (doneAt < 0) doneAt = c;
         end
         halted = (doneAt < 0) || (c <= doneAt);
         if (oCe !== (ceIn & ~halted)) gateBad++;
         if (c == intrudeAt && oRdy !== 1'b0) readyBad++;
         if (oHw) begin
            wrQ.push_back({oWa, oWd});
            wrCycQ.push_back(c);
            if (!sel) cpuRegs[oWa] = oWd;
         end
         cmdValid = (c == intrudeAt);
         bufWe    = (c == intrudeAt);
         bufAddr  = 3'd7;
         bufWd    = 8'h5A;
         if (ceRand) ceIn = 1'($urandom);
         if (doneAt >= 0 && c >= doneAt + 2) break;
      end
      cmdValid = 1'b0; bufWe = 1'b0;
      chk({tag, "_doneCycle"}, doneAt, expDone);
      chk({tag, "_doneCount"}, nDone, 1);
      chk({tag, "_gating"}, gateBad, 0);
      if (intrudeAt > 0) chk({tag, "_readyWhileBusy"}, readyBad, 0);
      if (restore) begin
         chk({tag, "_writeCount"}, wrQ.size(), R);
         for (int k = 0; k < wrQ.size() && k < R; k++) begin
            chk($sformatf("%s_write%0d", tag, k), {21'd0, wrQ[k]}, {21'd0, 3'(k), bufModel[k]});
            chk($sformatf("%s_writeCycle%0d", tag, k), wrCycQ[k], h + 1 + k);
         end
      end else begin
         chk({tag, "_noWrites"}, wrQ.size(), 0);
         for (int i = 0; i < R; i++) bufModel[i] = cpuRegs[i];
      end
      chk({tag, "_readyAfter"}, {31'd0, oRdy}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nWr;
      for (int i = 0; i < 8; i++) begin
         cpuRegs[i]  = 8'h00;
         bufModel[i] = 8'h00;
      end

      // Reset state
      @(negedge clock);
      chk("rst_cmdReady", {31'd0, rdy1}, 1);
      chk("rst_busy", {31'd0, busy1}, 0);
      chk("rst_done", {31'd0, done1}, 0);
      chk("rst_hw", {31'd0, hw1}, 0);
      chk("rst_writeAddrData", {21'd0, wa1, wd1}, 0);
      chk("rst_readAddr", {26'd0, ra1, rb1}, 0);
      chk("rst_bufReadData", {24'd0, brd1}, 0);
      chk("rst_ce0", {31'd0, ce1}, 0);
      ceIn = 1'b1;
      #1 chk("rst_ce1", {31'd0, ce1}, 1);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);

      // Directed save with a rejected second command at cycle 3
      for (int i = 0; i < 8; i++) cpuRegs[i] = 8'h10 + 8'(i);
      runCmd(1'b0, 1, 3, 1'b1, 1'b0, 3'd0, 8'h00, "save");
      checkBuf("save");

      // Directed restore, busy-time buffer write to index 7 must be ignored
      for (int i = 0; i < 8; i++) begin
         bufWrite(3'(i), 8'hA0 + 8'(i));
         bufModel[i] = 8'hA0 + 8'(i);
      end
      runCmd(1'b1, 1, 3, 1'b1, 1'b0, 3'd0, 8'h00, "restore");
      for (int i = 0; i < 8; i++) chk($sformatf("restore_cpu%0d", i), {24'd0, cpuRegs[i]}, {24'd0, 8'hA0 + 8'(i)});
      checkBuf("restore");

      // Randomized mix of host writes, saves and restores
      for (int it = 0; it < 6; it++) begin
         logic op;
         for (int i = 0; i < 8; i++) cpuRegs[i] = 8'($urandom);
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            logic [2:0] a;
            logic [7:0] d;
            a = 3'($urandom); d = 8'($urandom);
            bufWrite(a, d);
            bufModel[a] = d;
         end
         op = 1'($urandom);
         runCmd(op, 1, (it % 2 == 0) ? int'($urandom_range(2, 5)) : 0, 1'b1,
                ~op, 3'($urandom), 8'($urandom), $sformatf("rand%0d", it));
         checkBuf($sformatf("rand%0d", it));
      end

      // Reset in the middle of a restore, after three writes
      for (int i = 0; i < 8; i++) begin
         bufWrite(3'(i), 8'hC0 + 8'(i));
         bufModel[i] = 8'hC0 + 8'(i);
      end
      ceIn = 1'b1; cmdRestore = 1'b1; cmdValid = 1'b1;
      nWr = 0;
      for (int c = 1; c <= 20 && nWr < 3; c++) begin
         @(negedge clock);
         cmdValid = 1'b0;
         if (hw1) nWr++;
      end
      chk("midrst_threeWrites", nWr, 3);
      @(posedge clock);
      #2 chk("midrst_hwBefore", {31'd0, hw1}, 1);
      resetN = 1'b0;
      #1;
      chk("midrst_hw", {31'd0, hw1}, 0);
      chk("midrst_ce", {31'd0, ce1}, 1);
      chk("midrst_busy", {31'd0, busy1}, 0);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      chk("midrst_cmdReady", {31'd0, rdy1}, 1);
      for (int i = 0; i < 8; i++) bufModel[i] = 8'h00;
      checkBuf("midrst");

      // HALT_CYCLES=4 instance, enable tied high
      sel = 1'b1; ceIn = 1'b1;
      for (int i = 0; i < 8; i++) cpuRegs[i] = 8'h30 + 8'(i);
      runCmd(1'b0, 4, 0, 1'b0, 1'b0, 3'd0, 8'h00, "h4save");
      checkBuf("h4save");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
